otp_prog_seq: RTL and testbench

OTP_PROG_SEQ -- requirements
Module: otp_prog_seq

---
 rtl/otp_prog_seq.sv | 227 ++++++++++++++++++++++
 tb/tb_otp_prog_seq.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otp_prog_seq.sv
// OTP word programming sequencer: burns NumWords words through a req/gnt/rvalid OTP port.
// Define OTP_PROG_SEQ_VERIFY_EN to add a read-back compare after every successful write.
module otp_prog_seq #(
    parameter int          NumWords  = 12,
    parameter int          WordWidth = 16,
    parameter int          AddrWidth = 10,
    parameter int unsigned BaseAddr  = 0,
    parameter int          StopOnErr = 0,
    localparam int         CntW      = $clog2(NumWords + 1)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          en_i,
    input  logic                          escalate_i,
    input  logic                          req_i,
    input  logic [NumWords*WordWidth-1:0] data_i,
    output logic                          ack_o,
    output logic                          err_o,
    output logic [2:0]                    err_code_o,
    output logic [CntW-1:0]               fail_cnt_o,
    output logic                          idle_o,
    output logic                          fsm_err_o,
    output logic                          otp_req_o,
    output logic                          otp_cmd_o,
    output logic [AddrWidth-1:0]          otp_addr_o,
    output logic [WordWidth-1:0]          otp_wdata_o,
    input  logic                          otp_gnt_i,
    input  logic                          otp_rvalid_i,
    input  logic [WordWidth-1:0]          otp_rdata_i,
    input  logic [2:0]                    otp_err_i
);

    // Codewords of the extended Hamming code: any two differ in at least 4 bits.
    typedef enum logic [7:0] {
        ResetSt      = 8'b0000_1111,
        IdleSt       = 8'b0011_0011,
        WriteSt      = 8'b0101_0101,
        WriteWaitSt  = 8'b1111_0000,
`ifdef OTP_PROG_SEQ_VERIFY_EN
        VerifySt     = 8'b1100_1100,
        VerifyWaitSt = 8'b1010_1010,
`endif
        ErrorSt      = 8'b0011_1100
    } state_e;

    state_e                r_state;
    state_e                w_next;
    logic [CntW-1:0]       r_idx;
    logic [CntW-1:0]       r_idx_inv;
    logic [CntW-1:0]       r_fail_cnt;
    logic [2:0]            r_err_code;

    logic [WordWidth-1:0]  w_word;
    logic [CntW-1:0]       w_idx_plus;
    logic [CntW-1:0]       w_fail_cnt_next;
    logic                  w_illegal;
    logic                  w_cnt_err;
    logic                  w_fsm_err;
    logic                  w_ack;
    logic                  w_err;
    logic                  w_advance;
    logic                  w_idx_clr;
    logic                  w_idx_inc;
    logic                  w_fail_now;
    logic [2:0]            w_fail_code;

    always_comb begin
        w_word = '0;
        for (int k = 0; k < NumWords; k++) begin
            if (r_idx == CntW'(k)) w_word = data_i[k*WordWidth +: WordWidth];
        end
    end

    always_comb begin
        w_illegal = 1'b1;
        case (r_state)
            ResetSt, IdleSt, WriteSt, WriteWaitSt, ErrorSt: w_illegal = 1'b0;
`ifdef OTP_PROG_SEQ_VERIFY_EN
            VerifySt, VerifyWaitSt:                          w_illegal = 1'b0;
`endif
            default:                                         w_illegal = 1'b1;
        endcase
    end

    // The index is held twice (true and inverted); any disagreement or out-of-range value is a fault.
    assign w_cnt_err  = (r_idx != ~r_idx_inv) || (r_idx > CntW'(NumWords - 1));
    assign w_fsm_err  = escalate_i || w_illegal || w_cnt_err;
    assign w_idx_plus = r_idx + CntW'(1);

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        w_next      = r_state;
        w_ack       = 1'b0;
        w_err       = 1'b0;
        w_advance   = 1'b0;
        w_idx_clr   = 1'b0;
        w_idx_inc   = 1'b0;
        w_fail_now  = 1'b0;
        w_fail_code = 3'd0;

        case (r_state)
            ResetSt: if (en_i) w_next = IdleSt;
            IdleSt: begin
                if (req_i) begin
                    w_next    = WriteSt;
                    w_idx_clr = 1'b1;
                end
            end
            WriteSt: begin
                if (w_word == '0)   w_advance = 1'b1;
                else if (otp_gnt_i) w_next    = WriteWaitSt;
            end
            WriteWaitSt: begin
                if (otp_rvalid_i) begin
                    if (otp_err_i != 3'd0) begin
                        w_fail_now  = 1'b1;
                        w_fail_code = otp_err_i;
                    end
                    if (w_fail_now && (StopOnErr != 0)) begin
                        w_ack  = 1'b1;
                        w_err  = 1'b1;
                        w_next = ErrorSt;
                    end else begin
`ifdef OTP_PROG_SEQ_VERIFY_EN
                        // A word whose write already failed is not worth reading back.
                        if (w_fail_now) w_advance = 1'b1;
                        else            w_next    = VerifySt;
`else
                        w_advance = 1'b1;
`endif
                    end
                end
            end
`ifdef OTP_PROG_SEQ_VERIFY_EN
            VerifySt: if (otp_gnt_i) w_next = VerifyWaitSt;
            VerifyWaitSt: begin
                if (otp_rvalid_i) begin
                    if (otp_err_i != 3'd0) begin
                        w_fail_now  = 1'b1;
                        w_fail_code = otp_err_i;
                    end else if (otp_rdata_i != w_word) begin
                        w_fail_now  = 1'b1;
                        w_fail_code = 3'd4;
                    end
                    if (w_fail_now && (StopOnErr != 0)) begin
                        w_ack  = 1'b1;
                        w_err  = 1'b1;
                        w_next = ErrorSt;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
`endif
            ErrorSt: w_next = ErrorSt;
            default: w_next = ErrorSt;
        endcase

        w_fail_cnt_next = r_fail_cnt + CntW'(w_fail_now);

        if (w_advance) begin
            if (r_idx == CntW'(NumWords - 1)) begin
                w_ack  = 1'b1;
                w_err  = (w_fail_cnt_next != '0);
                w_next = w_err ? ErrorSt : IdleSt;
            end else begin
                w_idx_inc = 1'b1;
                w_next    = WriteSt;
            end
        end

        // Faults and escalation override everything: no ack, no bookkeeping, straight to ErrorSt.
        if (w_fsm_err) begin
            w_next     = ErrorSt;
            w_ack      = 1'b0;
            w_err      = 1'b0;
            w_idx_clr  = 1'b0;
            w_idx_inc  = 1'b0;
            w_fail_now = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ResetSt;
            r_idx      <= '0;
            r_idx_inv  <= '1;
            r_fail_cnt <= '0;
            r_err_code <= 3'd0;
        end else begin
            r_state <= w_next;
            if (w_idx_clr) begin
                r_idx     <= '0;
                r_idx_inv <= '1;
            end else if (w_idx_inc) begin
                r_idx     <= w_idx_plus;
                r_idx_inv <= ~w_idx_plus;
            end
            if (w_idx_clr)       r_fail_cnt <= '0;
            else if (w_fail_now) r_fail_cnt <= w_fail_cnt_next;
            if (r_err_code == 3'd0) begin
                if (w_fsm_err || (r_state == ErrorSt)) r_err_code <= 3'd7;
                else if (w_fail_now)                   r_err_code <= w_fail_code;
            end
        end
    end

    assign ack_o      = w_ack;
    assign err_o      = w_err;
    assign fsm_err_o  = w_fsm_err;
    assign err_code_o = r_err_code;
    assign fail_cnt_o = r_fail_cnt;
    assign idle_o     = (r_state == IdleSt) || (r_state == ErrorSt);

`ifdef OTP_PROG_SEQ_VERIFY_EN
    assign otp_req_o = ((r_state == WriteSt) && (w_word != '0)) || (r_state == VerifySt);
`else
    logic w_unused_rdata;
    assign w_unused_rdata = ^otp_rdata_i;
    assign otp_req_o      = (r_state == WriteSt) && (w_word != '0);
`endif
    assign otp_cmd_o   = (r_state == WriteSt);
    assign otp_addr_o  = AddrWidth'(BaseAddr) + AddrWidth'(r_idx);
    assign otp_wdata_o = otp_req_o ? w_word : '0;

endmodule

// File: tb/tb_otp_prog_seq.sv
// Directed bench for otp_prog_seq: two instances (aggregate errors / stop on first error)
// share one OTP responder that grants a request one cycle later and answers one cycle after that.
module tb_otp_prog_seq;

    localparam int NW   = 4;
    localparam int WW   = 16;
    localparam int AW   = 10;
    localparam int BASE = 16;

    logic            clk = 1'b0;
    logic            rst, en, esc, req;
    logic [NW*WW-1:0] data;
    logic            gnt, rvalid;
    logic [WW-1:0]   rdata;
    logic [2:0]      rsp_err;
    logic            sel;

    logic            a_ack, a_err, a_idle, a_fsm_err, a_req, a_cmd;
    logic [2:0]      a_code, a_fail;
    logic [AW-1:0]   a_addr;
    logic [WW-1:0]   a_wdata;
    logic            b_ack, b_err, b_idle, b_fsm_err, b_req, b_cmd;
    logic [2:0]      b_code, b_fail;
    logic [AW-1:0]   b_addr;
    logic [WW-1:0]   b_wdata;

    always #5 clk = ~clk;

    otp_prog_seq #(.NumWords(NW), .WordWidth(WW), .AddrWidth(AW), .BaseAddr(BASE), .StopOnErr(0)) u_dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .escalate_i(esc), .req_i(req), .data_i(data),
        .ack_o(a_ack), .err_o(a_err), .err_code_o(a_code), .fail_cnt_o(a_fail), .idle_o(a_idle),
        .fsm_err_o(a_fsm_err), .otp_req_o(a_req), .otp_cmd_o(a_cmd), .otp_addr_o(a_addr),
        .otp_wdata_o(a_wdata), .otp_gnt_i(gnt), .otp_rvalid_i(rvalid), .otp_rdata_i(rdata),
        .otp_err_i(rsp_err));

    otp_prog_seq #(.NumWords(NW), .WordWidth(WW), .AddrWidth(AW), .BaseAddr(BASE), .StopOnErr(1)) u_dut_stop (
        .clk_i(clk), .rst_i(rst), .en_i(en), .escalate_i(esc), .req_i(req), .data_i(data),
        .ack_o(b_ack), .err_o(b_err), .err_code_o(b_code), .fail_cnt_o(b_fail), .idle_o(b_idle),
        .fsm_err_o(b_fsm_err), .otp_req_o(b_req), .otp_cmd_o(b_cmd), .otp_addr_o(b_addr),
        .otp_wdata_o(b_wdata), .otp_gnt_i(gnt), .otp_rvalid_i(rvalid), .otp_rdata_i(rdata),
        .otp_err_i(rsp_err));

    wire          s_req   = sel ? b_req     : a_req;
    wire          s_cmd   = sel ? b_cmd     : a_cmd;
    wire [AW-1:0] s_addr  = sel ? b_addr    : a_addr;
    wire [WW-1:0] s_wdata = sel ? b_wdata   : a_wdata;
    wire          s_ack   = sel ? b_ack     : a_ack;
    wire          s_err   = sel ? b_err     : a_err;
    wire          s_fsm   = sel ? b_fsm_err : a_fsm_err;

    // Main-process-owned error injection tables, indexed by word offset.
    logic [2:0]    wr_err_tab [8];
    logic [WW-1:0] rd_flip    [8];

    // Responder/monitor-owned logs and counters.
    logic [AW-1:0] wr_addr [64];
    logic [WW-1:0] wr_data [64];
    logic [WW-1:0] wmem    [8];
    int            wr_cnt = 0, rd_cnt = 0, ack_cnt = 0, fsm_cnt = 0;
    int            ack_off = -1, rsp_off = -1, r_off = 0;
    logic          last_ack_err = 1'b0;
    logic          pend = 1'b0, pend_cmd = 1'b0;
    logic [AW-1:0] pend_addr = '0;
    logic [WW-1:0] pend_wdata = '0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // OTP model: grant at the first negedge a request is seen, answer at the next one, then sample.
    initial begin
        gnt = 1'b0; rvalid = 1'b0; rdata = '0; rsp_err = 3'd0;
        for (int i = 0; i < 8; i++) wmem[i] = '0;
        forever begin
            @(negedge clk);
            gnt = 1'b0; rvalid = 1'b0; rdata = '0; rsp_err = 3'd0; rsp_off = -1;
            if (rst) begin
                pend = 1'b0;
            end else if (pend) begin
                r_off = int'(pend_addr) - BASE;
                if (r_off < 0 || r_off > 7) r_off = 7;
                rvalid  = 1'b1;
                rsp_off = r_off;
                if (pend_cmd) begin
                    rsp_err     = wr_err_tab[r_off];
                    wmem[r_off] = pend_wdata;
                end else begin
                    rdata = wmem[r_off] ^ rd_flip[r_off];
                end
                pend = 1'b0;
            end else if (s_req) begin
                gnt        = 1'b1;
                pend       = 1'b1;
                pend_cmd   = s_cmd;
                pend_addr  = s_addr;
                pend_wdata = s_wdata;
                if (s_cmd) begin
                    if (wr_cnt < 64) begin
                        wr_addr[wr_cnt] = s_addr;
                        wr_data[wr_cnt] = s_wdata;
                    end
                    wr_cnt++;
                end else begin
                    rd_cnt++;
                end
            end
            #2;
            if (s_ack) begin
                ack_cnt++;
                last_ack_err = s_err;
                ack_off      = rsp_off;
            end
            if (s_fsm) fsm_cnt++;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req = 1'b0; esc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_err_tab[i] = 3'd0;
            rd_flip[i]    = '0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // Hold req until the selected DUT acks (bounded); leaves req low before the ack edge.
    task automatic run_seq(input string tag);
        int  start;
        bit  got;
        start = ack_cnt;
        got   = 1'b0;
        @(negedge clk);
        req = 1'b1;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            #3;
            if (ack_cnt != start) got = 1'b1;
        end
        req = 1'b0;
        check(tag, 32'(got), 32'd1);
    endtask

    initial begin
        int wr0, rd0, a0, f0, hits;
        bit seen;
        rst = 1'b1; en = 1'b0; esc = 1'b0; req = 1'b0; sel = 1'b0; data = '0;
        for (int i = 0; i < 8; i++) begin
            wr_err_tab[i] = 3'd0;
            rd_flip[i]    = '0;
        end
        repeat (3) @(negedge clk);
        #3;
        check("rst_idle",    32'(a_idle),    32'd0);
        check("rst_ack",     32'(a_ack),     32'd0);
        check("rst_err",     32'(a_err),     32'd0);
        check("rst_otp_req", 32'(a_req),     32'd0);
        check("rst_code",    32'(a_code),    32'd0);
        check("rst_fail",    32'(a_fail),    32'd0);
        check("rst_fsm_err", 32'(a_fsm_err), 32'd0);

        // Without en_i the block stays in ResetSt and ignores req_i.
        @(negedge clk);
        rst = 1'b0; req = 1'b1; data = 64'h4444_3333_2222_1111;
        wr0 = wr_cnt;
        repeat (4) @(negedge clk);
        #3;
        check("no_en_idle",   32'(a_idle),       32'd0);
        check("no_en_writes", 32'(wr_cnt - wr0), 32'd0);
        @(negedge clk);
        req = 1'b0; en = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        check("en_idle",        32'(a_idle),  32'd1);
        check("idle_wdata_zero", 32'(a_wdata), 32'd0);

        // Four nonzero words, no errors; repeated to prove the return to IdleSt.
        wr0 = wr_cnt; rd0 = rd_cnt; a0 = ack_cnt;
        run_seq("t1_ack_seen");
        check("t1_ack_err",   32'(last_ack_err),  32'd0);
        check("t1_writes",    32'(wr_cnt - wr0),  32'd4);
        for (int i = 0; i < NW; i++) begin
            check($sformatf("t1_addr%0d", i), 32'(wr_addr[wr0+i]), 32'(BASE + i));
            check($sformatf("t1_data%0d", i), 32'(wr_data[wr0+i]), 32'(16'h1111 * (i + 1)));
        end
`ifdef OTP_PROG_SEQ_VERIFY_EN
        check("t1_reads", 32'(rd_cnt - rd0), 32'd4);
`endif
        @(negedge clk);
        #3;
        check("t1_idle", 32'(a_idle), 32'd1);
        check("t1_code", 32'(a_code), 32'd0);
        check("t1_fail", 32'(a_fail), 32'd0);
        run_seq("t1b_ack_seen");
        check("t1b_acks",   32'(ack_cnt - a0), 32'd2);
        check("t1b_writes", 32'(wr_cnt - wr0), 32'd8);

        // Word 1 all-zero is skipped.
        data = 64'h4444_3333_0000_1111;
        wr0 = wr_cnt;
        run_seq("t2_ack_seen");
        check("t2_ack_err", 32'(last_ack_err), 32'd0);
        check("t2_writes",  32'(wr_cnt - wr0), 32'd3);
        hits = 0;
        for (int i = wr0; i < wr_cnt; i++) if (wr_addr[i] == AW'(BASE + 1)) hits++;
        check("t2_no_word1", 32'(hits), 32'd0);
        check("t2_last_addr", 32'(wr_addr[wr_cnt-1]), 32'(BASE + 3));

        // Aggregated errors: code 2 on word 0, code 3 on word 2.
        do_reset();
        data = 64'h4444_3333_2222_1111;
        wr_err_tab[0] = 3'd2; wr_err_tab[2] = 3'd3;
        wr0 = wr_cnt; a0 = ack_cnt;
        run_seq("t3_ack_seen");
        check("t3_ack_err", 32'(last_ack_err),  32'd1);
        check("t3_writes",  32'(wr_cnt - wr0),  32'd4);
        @(negedge clk);
        #3;
        check("t3_code", 32'(a_code), 32'd2);
        check("t3_fail", 32'(a_fail), 32'd2);
        check("t3_idle", 32'(a_idle), 32'd1);
        req = 1'b1;
        repeat (10) @(negedge clk);
        #3;
        req = 1'b0;
        check("t3_terminal_writes", 32'(wr_cnt - wr0),  32'd4);
        check("t3_terminal_acks",   32'(ack_cnt - a0),  32'd1);
        check("t3_terminal_code",   32'(a_code),        32'd2);

        // Stop on first error: error on word 1, no word 2.
        do_reset();
        sel = 1'b1;
        wr_err_tab[1] = 3'd3;
        wr0 = wr_cnt;
        run_seq("t4_ack_seen");
        check("t4_ack_err",  32'(last_ack_err),      32'd1);
        check("t4_ack_word", 32'(ack_off),           32'd1);
        repeat (5) @(negedge clk);
        #3;
        check("t4_writes",    32'(wr_cnt - wr0),      32'd2);
        check("t4_last_addr", 32'(wr_addr[wr_cnt-1]), 32'(BASE + 1));
        check("t4_code",      32'(b_code),            32'd3);
        check("t4_fail",      32'(b_fail),            32'd1);
        check("t4_idle",      32'(b_idle),            32'd1);
        sel = 1'b0;

        // Escalation while waiting for the first write response.
        do_reset();
        wr0 = wr_cnt; a0 = ack_cnt; f0 = fsm_cnt;
        seen = 1'b0;
        @(negedge clk);
        req = 1'b1;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (gnt) seen = 1'b1;
        end
        check("t5_gnt_seen", 32'(seen), 32'd1);
        @(negedge clk);
        esc = 1'b1;
        @(negedge clk);
        esc = 1'b0; req = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        check("t5_fsm_err_pulses", 32'(fsm_cnt - f0), 32'd1);
        check("t5_no_ack",         32'(ack_cnt - a0), 32'd0);
        check("t5_code",           32'(a_code),       32'd7);
        check("t5_idle",           32'(a_idle),       32'd1);
        check("t5_writes",         32'(wr_cnt - wr0), 32'd1);
        check("t5_otp_req",        32'(a_req),        32'd0);

`ifdef OTP_PROG_SEQ_VERIFY_EN
        // Read-back of word 2 differs in bit 0.
        do_reset();
        rd_flip[2] = 16'h0001;
        wr0 = wr_cnt; rd0 = rd_cnt;
        run_seq("t6_ack_seen");
        check("t6_ack_err", 32'(last_ack_err),  32'd1);
        check("t6_writes",  32'(wr_cnt - wr0),  32'd4);
        check("t6_reads",   32'(rd_cnt - rd0),  32'd4);
        @(negedge clk);
        #3;
        check("t6_code", 32'(a_code), 32'd4);
        check("t6_fail", 32'(a_fail), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
